// File: rtl/nn_pkg.sv
// Shared constants and types for the fully-connected layer: geometry,
// datapath widths and the sequencer state encoding.
package nn_pkg;

  localparam int N_IN      = 784;
  localparam int N_OUT     = 10;
  localparam int ADDR_W    = 13;
  localparam int XADDR_W   = 10;
  localparam int W_W       = 8;
  localparam int X_W       = 8;
  localparam int ACC_W     = 26;
  localparam int IDX_W     = 4;
  localparam int ROM_DEPTH = N_IN * N_OUT;
  localparam int PROD_W    = W_W + X_W + 1;

  localparam logic [ADDR_W-1:0]  LAST_W_ADDR = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [XADDR_W-1:0] LAST_IN     = XADDR_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]   LAST_OUT    = IDX_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Signed weight times unsigned pixel, sign-extended to accumulator width.
  function automatic logic signed [ACC_W-1:0] mul_ext(input logic [W_W-1:0] w,
                                                      input logic [X_W-1:0] x);
    logic signed [PROD_W-1:0] p;
    p = $signed(w) * $signed({1'b0, x});
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed x unsigned multiply followed by accumulate. The acc output
// already includes any product still in flight, so it is final one cycle after en drops.
module mac_unit
  import nn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [W_W-1:0]          w,
  input  logic [X_W-1:0]          x,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] prod_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    prod_v_r;

  // running sum including the pending product
  always_comb begin
    acc = acc_r;
    if (prod_v_r) begin
      acc = acc_r + prod_r;
    end else begin
      acc = acc_r;
    end
  end

  // product pipeline stage and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r   <= '0;
      prod_v_r <= 1'b0;
      acc_r    <= '0;
    end else if (clr) begin
      prod_r   <= '0;
      prod_v_r <= 1'b0;
      acc_r    <= '0;
    end else begin
      acc_r <= acc;
      if (en) begin
        prod_r   <= mul_ext(w, x);
        prod_v_r <= 1'b1;
      end else begin
        prod_v_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dense_layer_mac.sv
// Sequencer for one fully-connected layer: streams weights/pixels through the
// MAC, emits one dot product per neuron, then pulses done.
module dense_layer_mac
  import nn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  w_addr,
  input  logic [W_W-1:0]     w_data,
  output logic [XADDR_W-1:0] x_addr,
  input  logic [X_W-1:0]     x_data,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [ACC_W-1:0]   out_acc
);

  state_t                  state_r, state_s;
  logic [XADDR_W-1:0]      in_idx_r;
  logic [IDX_W-1:0]        neuron_r;
  logic                    last_in_s, last_neuron_s;
  logic                    mac_clr_s, mac_en_s, busy_s, done_s, valid_s;
  logic signed [ACC_W-1:0] acc_s;

  assign last_in_s     = (in_idx_r == LAST_IN);
  assign last_neuron_s = (neuron_r == LAST_OUT);

  mac_unit u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr_s),
    .en  (mac_en_s),
    .w   (w_data),
    .x   (x_data),
    .acc (acc_s)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? RUN : IDLE;
      RUN:     state_s = last_in_s ? DRAIN : RUN;
      DRAIN:   state_s = EMIT;
      EMIT:    state_s = last_neuron_s ? DONE : RUN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // control decode; status outputs are derived from the next state so they register in step with it
  always_comb begin
    mac_en_s  = (state_r == RUN);
    mac_clr_s = (state_r == IDLE) || (state_r == EMIT);
    busy_s    = (state_s != IDLE);
    done_s    = (state_s == DONE);
    valid_s   = (state_s == EMIT);
  end

  // counters, addresses and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_acc   <= '0;
      w_addr    <= '0;
      x_addr    <= '0;
      in_idx_r  <= '0;
      neuron_r  <= '0;
    end else begin
      busy      <= busy_s;
      done      <= done_s;
      out_valid <= valid_s;
      if (valid_s) begin
        out_idx <= neuron_r;
        out_acc <= acc_s;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            neuron_r <= '0;
            in_idx_r <= '0;
            w_addr   <= '0;
            x_addr   <= '0;
          end
        end
        RUN: begin
          // wrap at the end of the ROM so the address never leaves 0..ROM_DEPTH-1
          w_addr <= (w_addr == LAST_W_ADDR) ? '0 : w_addr + ADDR_W'(1);
          if (last_in_s) begin
            x_addr <= '0;
          end else begin
            in_idx_r <= in_idx_r + XADDR_W'(1);
            x_addr   <= x_addr + XADDR_W'(1);
          end
        end
        EMIT: begin
          in_idx_r <= '0;
          if (!last_neuron_s) begin
            neuron_r <= neuron_r + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Scoreboard bench for dense_layer_mac: ROM/buffer models, per-neuron expected
// results queued at start and compared as out_valid strobes arrive.
module tb_dense_layer_mac;
  import nn_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               busy, done, out_valid;
  logic [ADDR_W-1:0]  w_addr;
  logic [W_W-1:0]     w_data;
  logic [XADDR_W-1:0] x_addr;
  logic [X_W-1:0]     x_data;
  logic [IDX_W-1:0]   out_idx;
  logic [ACC_W-1:0]   out_acc;

  logic [7:0] rom  [0:8191];
  logic [7:0] xbuf [0:1023];
  longint     exp_acc [0:9];
  longint     acc_q[$];
  int         idx_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  assign w_data = rom[w_addr];
  assign x_data = xbuf[x_addr];

  dense_layer_mac dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_addr(w_addr), .w_data(w_data), .x_addr(x_addr), .x_data(x_data),
    .out_valid(out_valid), .out_idx(out_idx), .out_acc(out_acc)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: 1/1, 1: -1/255, 2: -128/255, 3: row k = k with pixel 1, 4: random
  task automatic fill(input int mode);
    for (int k = 0; k < N_OUT; k++) begin
      for (int i = 0; i < N_IN; i++) begin
        case (mode)
          0: begin rom[k*N_IN+i] = 8'h01; xbuf[i] = 8'h01; end
          1: begin rom[k*N_IN+i] = 8'hFF; xbuf[i] = 8'hFF; end
          2: begin rom[k*N_IN+i] = 8'h80; xbuf[i] = 8'hFF; end
          3: begin rom[k*N_IN+i] = 8'(k); xbuf[i] = 8'h01; end
          default: begin
            rom[k*N_IN+i] = 8'($urandom_range(0, 255));
            if (k == 0) xbuf[i] = 8'($urandom_range(0, 255));
          end
        endcase
      end
    end
    for (int k = 0; k < N_OUT; k++) begin
      case (mode)
        0: exp_acc[k] = 784;
        1: exp_acc[k] = -199920;
        2: exp_acc[k] = -25589760;
        3: exp_acc[k] = 784 * k;
        default: begin
          longint s;
          byte signed wv;
          s = 0;
          for (int i = 0; i < N_IN; i++) begin
            wv = byte'(rom[k*N_IN+i]);
            s += longint'(wv) * longint'(xbuf[i]);
          end
          exp_acc[k] = s;
        end
      endcase
    end
  endtask

  // one layer run; abort_at>0 asserts rst in that cycle, extra pulses start at 100 and 5000
  task automatic run_layer(input string nm, input int abort_at, input bit extra);
    int done_cnt, done_cyc, werr, xerr, wmax, p, k, e_idx;
    longint e_acc, a;
    done_cnt = 0; done_cyc = -1; werr = 0; xerr = 0; wmax = 0;
    for (int n = 0; n < N_OUT; n++) begin
      idx_q.push_back(n);
      acc_q.push_back(exp_acc[n]);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 7865; cyc++) begin
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        chk({nm, ".rst_busy"}, longint'(busy), 0);
        chk({nm, ".rst_valid"}, longint'(out_valid), 0);
        chk({nm, ".rst_done"}, longint'(done), 0);
        chk({nm, ".rst_waddr"}, longint'(w_addr), 0);
        @(negedge clk); rst = 1'b0;
        idx_q.delete(); acc_q.delete();
        return;
      end
      if (cyc == 1) chk({nm, ".busy1"}, longint'(busy), 1);
      if (cyc == 1) chk({nm, ".waddr_first"}, longint'(w_addr), 0);
      if (cyc == 787) chk({nm, ".waddr_n1"}, longint'(w_addr), 784);
      if (cyc == 7858) chk({nm, ".waddr_last"}, longint'(w_addr), 7839);
      if (cyc == 7862) chk({nm, ".busy_end"}, longint'(busy), 0);
      if (int'(w_addr) > wmax) wmax = int'(w_addr);
      p = (cyc - 1) % 786;
      k = (cyc - 1) / 786;
      if (k < N_OUT && p < N_IN) begin
        if (int'(w_addr) != k * N_IN + p) werr++;
        if (int'(x_addr) != p) xerr++;
      end
      if (out_valid) begin
        if (idx_q.size() == 0) begin
          chk({nm, ".spurious_valid"}, cyc, -1);
        end else begin
          e_idx = idx_q.pop_front();
          e_acc = acc_q.pop_front();
          a = longint'($signed(out_acc));
          chk({nm, ".idx"}, longint'(out_idx), e_idx);
          chk({nm, ".acc"}, a, e_acc);
          chk({nm, ".valid_cyc"}, cyc, 786 + 786 * e_idx);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      start = (extra && (cyc == 100 || cyc == 5000)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, ".missing_results"}, idx_q.size(), 0);
    chk({nm, ".done_count"}, done_cnt, 1);
    chk({nm, ".done_cyc"}, done_cyc, 7861);
    chk({nm, ".waddr_max"}, wmax, 7839);
    chk({nm, ".waddr_trace_errs"}, werr, 0);
    chk({nm, ".xaddr_trace_errs"}, xerr, 0);
    idx_q.delete(); acc_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 8'h00;
    for (int i = 0; i < 1024; i++) xbuf[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset.busy", longint'(busy), 0);
    chk("reset.done", longint'(done), 0);
    chk("reset.valid", longint'(out_valid), 0);
    chk("reset.waddr", longint'(w_addr), 0);
    chk("reset.xaddr", longint'(x_addr), 0);
    chk("reset.idx", longint'(out_idx), 0);
    chk("reset.acc", longint'(out_acc), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill(0); run_layer("ones", 0, 1'b0);
    fill(1); run_layer("neg1", 0, 1'b0);
    fill(2); run_layer("min_w", 0, 1'b0);
    fill(3); run_layer("rows", 0, 1'b0);
    fill(4); run_layer("random", 0, 1'b0);
    fill(0); run_layer("restart_ignored", 0, 1'b1);
    run_layer("abort", 3000, 1'b0);
    repeat (2) @(negedge clk);
    chk("post_abort.busy", longint'(busy), 0);
    run_layer("after_abort", 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dense_layer_mac.md
Name: dense_layer_mac

Overview:
- Downstream consumer of weight_rom; sequences the fully-connected layer (N_OUT neurons × N_IN inputs).
- Drives the weight_rom address and reads one weight per cycle. Reads the matching pixel from the input buffer in the same cycle.
- Accumulates each neuron's dot product and emits one accumulator result per neuron to the argmax/output stage.
- weight_rom and the input buffer are combinational reads: data is valid in the same cycle as the address.

Parameters:
- N_IN, 784, inputs per neuron (flattened 28×28 image)
- N_OUT, 10, neurons in the layer
- ADDR_W, 13, weight_rom address width (N_IN*N_OUT = 7840 entries)
- XADDR_W, 10, input buffer address width
- W_W, 8, weight width, signed two's complement
- X_W, 8, pixel width, unsigned
- ACC_W, 26, accumulator width, signed (covers ±128·255·784)

Ports:
- clk, in, 1, system clock, rising edge
- rst, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle request to run the layer; sampled only in IDLE
- busy, out, 1, high from the cycle after start is accepted through the DONE cycle
- done, out, 1, one-cycle pulse after the last neuron is emitted
- w_addr, out, ADDR_W, weight_rom address (registered)
- w_data, in, W_W, weight_rom data (combinational)
- x_addr, out, XADDR_W, input buffer address (registered)
- x_data, in, X_W, input buffer data (combinational)
- out_valid, out, 1, one-cycle strobe when out_acc/out_idx are valid
- out_idx, out, 4, neuron index of the result
- out_acc, out, ACC_W, signed dot product of the neuron

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0: busy, done, out_valid, w_addr, x_addr, out_idx, out_acc. Internal counters, the product register, prod_v and the accumulator are also 0.
- States: IDLE → RUN → DRAIN → EMIT → (RUN | DONE) → IDLE.
- IDLE:
  - start=1 → RUN; clear neuron=0, in_idx=0, w_addr=0, x_addr=0, acc=0, prod_v=0.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - prod_r <= signed(w_data) × signed({0,x_data}), sign-extended to ACC_W; prod_v <= 1.
  - If prod_v=1, acc <= acc + prod_r.
  - w_addr and x_addr increment by 1.
  - w_addr is a running counter; no multiplier is used for address generation.
  - If in_idx == N_IN−1 → DRAIN, with x_addr wrapped to 0. Otherwise in_idx++.
- DRAIN: acc <= acc + prod_r (last product); prod_v <= 0.
- EMIT: out_valid=1, out_idx=neuron, out_acc=acc (registered outputs). Then acc <= 0 and in_idx <= 0.
  - If neuron == N_OUT−1 → DONE.
  - Otherwise neuron++ → RUN. w_addr then continues at (neuron+1)·N_IN.
- DONE: done=1 for one cycle, busy=1 → IDLE.
- out_valid, out_idx, out_acc hold last values when not strobed; out_valid is 0 outside EMIT.
- Timing: start accepted at cycle 0.
  - Neuron k out_valid at cycle 786 + 786·k; each neuron takes 784 RUN + 1 DRAIN + 1 EMIT cycles.
  - Final out_valid at cycle 7860, done at cycle 7861, busy=0 from cycle 7862.
- Address range:
  - w_addr covers 0..7839 exactly once per run and never exceeds N_IN·N_OUT−1.
  - x_addr covers 0..783 once per neuron.
- start while busy: ignored; no restart and no effect on counters.
- start in the same cycle DONE exits: ignored (IDLE samples start on the next cycle).
- rst mid-run: immediate return to IDLE with all outputs 0; no partial out_valid or done. A new start then begins from neuron 0.
- No saturation; ACC_W is sized to never overflow for W_W=8, X_W=8, N_IN=784.

Decomposition:
- Package nn_pkg holds:
  - N_IN, N_OUT, ADDR_W, XADDR_W, W_W, X_W, ACC_W;
  - the state enum (IDLE, RUN, DRAIN, EMIT, DONE);
  - the weight_rom depth constant shared with weight_rom.
- Sub-module mac_unit:
  - registered signed×unsigned multiply plus accumulate;
  - inputs clr, en, w, x;
  - output acc.
- The FSM and address counters stay in dense_layer_mac.

Test Plan:
1. All weights 0x01, all pixels 0x01, start → 10 out_valid strobes with out_idx 0..9, each out_acc=784. First strobe at cycle 786, done at cycle 7861.
2. All weights 0xFF (−1), pixels 0xFF → every out_acc = −199920. Weights 0x80, pixels 0xFF → every out_acc = −25589760 (no overflow).
3. Address trace → w_addr=0 in the first RUN cycle, 784 at neuron 1 start, 7839 in the last RUN cycle. x_addr sequence 0..783 repeated 10 times. No value >7839.
4. Weights where neuron k's row is all k and pixel i = 1 → out_acc for idx k = 784·k, confirming row-major neuron/weight alignment.
5. Pulse start again at cycles 100 and 5000 → no effect: one done only, still at cycle 7861.
6. Assert rst at cycle 3000 → busy, out_valid, done=0 immediately, w_addr=0. Restart → results identical to scenario 1 timing.
